c1541_head_ctrl: RTL



---
 rtl/c1541_pkg.sv | 18 +
 rtl/c1541_byte_timer.sv | 47 ++++
 rtl/c1541_head_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/c1541_pkg.sv
// Shared constants, state encoding and byte-period helper for the 1541
// disk-side head controller.
package c1541_pkg;

  localparam int HTRACK_MAX = 83;  // highest half-track (track 42.5)
  localparam int HTRACK_RST = 34;  // half-track after reset (track 18)
  localparam int BYTE_LOW   = 64;  // clk32 cycles byte_n is held low

  typedef enum logic {WAIT_TRK, RUN} state_t;

  // clk32 cycles per GCR byte for a speed zone: 64*(16-freq)
  function automatic logic [10:0] byte_period(input logic [1:0] freq);
    logic [4:0] mul;
    mul = 5'd16 - {3'b000, freq};
    return {mul, 6'b000000};
  endfunction

endpackage

// File: rtl/c1541_byte_timer.sv
// Byte-period counter for the GCR stream.
// Ports:
//   clk32, reset : clock, async active-high reset
//   en           : count (head running on a formatted track)
//   clr          : force the counter back to 0 (not streaming)
//   freq         : speed zone, sampled at counter 0
//   tick0, tick2 : counter is 0 / 2 while enabled
//   win          : counter inside the byte_n-low window (3..3+BYTE_LOW-1)
module c1541_byte_timer
  import c1541_pkg::*;
(
  input  logic       clk32,
  input  logic       reset,
  input  logic       en,
  input  logic       clr,
  input  logic [1:0] freq,
  output logic       tick0,
  output logic       tick2,
  output logic       win
);

  localparam logic [9:0] WIN_LO = 10'd3;
  localparam logic [9:0] WIN_HI = 10'(3 + BYTE_LOW);

  logic [9:0]  cnt;
  logic [10:0] period;

  // The period is never below 832, so wrapping cannot coincide with
  // counter 0 and the previously sampled period is always the right one.
  always_ff @(posedge clk32 or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      period <= byte_period(2'd0);
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      if (cnt == 10'd0) period <= byte_period(freq);
      if ({1'b0, cnt} == period - 11'd1) cnt <= '0;
      else                               cnt <= cnt + 10'd1;
    end
  end

  assign tick0 = en && (cnt == 10'd0);
  assign tick2 = en && (cnt == 10'd2);
  assign win   = (cnt >= WIN_LO) && (cnt < WIN_HI);

endmodule

// File: rtl/c1541_head_ctrl.sv
// 1541 disk-side head controller: tracks the head from the stepper phases,
// requests track-buffer loads from the host, streams GCR bytes out of the
// buffer at the zone bit rate and commits written bytes back.
// Ports:
//   clk32, reset         : 32 MHz clock, async active-high reset
//   mtr, stp, freq, mode : VIA motor / stepper / zone / read(1)-write(0)
//   dout / din           : byte from / to the drive logic
//   sync_n, byte_n       : sync-mark and byte-ready strobes
//   htrack               : current half-track
//   trk_req/dirty/ack/len: host load handshake
//   buf_*                : dual-port track buffer (1-cycle read latency)
module c1541_head_ctrl
  import c1541_pkg::*;
(
  input  logic        clk32,
  input  logic        reset,
  input  logic        mtr,
  input  logic [1:0]  stp,
  input  logic [1:0]  freq,
  input  logic        mode,
  input  logic [7:0]  dout,
  output logic [7:0]  din,
  output logic        sync_n,
  output logic        byte_n,
  output logic [6:0]  htrack,
  output logic        trk_req,
  output logic        trk_dirty,
  input  logic        trk_ack,
  input  logic [12:0] trk_len,
  output logic [12:0] buf_addr,
  input  logic [7:0]  buf_rd_data,
  output logic [7:0]  buf_wr_data,
  output logic        buf_we
);

  localparam logic [6:0] HT_MAX = 7'(HTRACK_MAX);
  localparam logic [6:0] HT_RST = 7'(HTRACK_RST);

  state_t      state, state_nxt;
  logic [1:0]  stp_q, delta;
  logic [6:0]  ht_nxt;
  logic        step_chg, accept, active;
  logic        tick0, tick2, win, tk0, tk2;
  logic [12:0] len_q, addr;
  logic        first, mode_q, sync_q, prev_ff, rd_ff;

  // Stepper: the phase difference modulo 4 gives the step direction.
  assign delta = stp - stp_q;

  always_comb begin
    ht_nxt   = htrack;
    step_chg = 1'b0;
    if (delta == 2'd1 && htrack != HT_MAX) begin
      ht_nxt   = htrack + 7'd1;
      step_chg = 1'b1;
    end else if (delta == 2'd3 && htrack != 7'd0) begin
      ht_nxt   = htrack - 7'd1;
      step_chg = 1'b1;
    end
  end

  always_ff @(posedge clk32 or posedge reset) begin
    if (reset) state <= WAIT_TRK;
    else       state <= state_nxt;
  end

  // A real head move always wins over an ack or a byte boundary.
  always_comb begin
    state_nxt = state;
    if (step_chg)                          state_nxt = WAIT_TRK;
    else if (state == WAIT_TRK && trk_ack) state_nxt = RUN;
  end

  assign accept = (state == WAIT_TRK) && trk_ack && !step_chg;
  assign active = (state == RUN) && mtr && (len_q != 13'd0);

  c1541_byte_timer u_timer (
    .clk32 (clk32),
    .reset (reset),
    .en    (active),
    .clr   (state != RUN),
    .freq  (freq),
    .tick0 (tick0),
    .tick2 (tick2),
    .win   (win)
  );

  assign tk0   = tick0 && !step_chg;
  assign tk2   = tick2 && !step_chg;
  assign rd_ff = (buf_rd_data == 8'hFF);

  // At each byte boundary the byte that just finished is committed to its
  // own (pre-advance) address; the first boundary after a load has no
  // finished byte behind it, so it neither writes nor advances.
  assign buf_addr    = addr;
  assign buf_we      = tk0 && !mode_q && !first;
  assign buf_wr_data = buf_we ? dout : 8'h00;

  assign sync_n = sync_q || !active;
  assign byte_n = !(active && win && sync_q);

  always_ff @(posedge clk32 or posedge reset) begin
    if (reset) begin
      stp_q     <= 2'd0;
      htrack    <= HT_RST;
      trk_req   <= 1'b0;
      trk_dirty <= 1'b0;
      len_q     <= '0;
      addr      <= '0;
      first     <= 1'b1;
      mode_q    <= 1'b1;
      din       <= 8'h00;
      sync_q    <= 1'b1;
      prev_ff   <= 1'b0;
    end else begin
      stp_q  <= stp;
      htrack <= ht_nxt;
      // A head move forces one low cycle so the host sees a fresh edge.
      trk_req <= (state_nxt == WAIT_TRK) && !step_chg;
      if (buf_we) trk_dirty <= 1'b1;
      if (accept) begin
        len_q     <= trk_len;
        addr      <= '0;
        first     <= 1'b1;
        trk_dirty <= 1'b0;
        sync_q    <= 1'b1;
        prev_ff   <= 1'b0;
      end
      if (tk0) begin
        first  <= 1'b0;
        mode_q <= mode;  // mode switches only on a byte boundary
        if (!first) addr <= (addr == len_q - 13'd1) ? 13'd0 : addr + 13'd1;
      end
      if (tk2) begin
        if (mode_q) begin
          din     <= buf_rd_data;
          sync_q  <= !(rd_ff && prev_ff);
          prev_ff <= rd_ff;
        end else begin
          sync_q  <= 1'b1;
          prev_ff <= 1'b0;
        end
      end
    end
  end

endmodule
